// File: rtl/mem_io_ctrl.sv
`default_nettype none
// ============================================================================
//  mem_io_ctrl : memory / memory-mapped I/O access controller with keyboard
//                and display device registers.
//  Revision    : 1.0
// ============================================================================
module mem_io_ctrl #(
  parameter logic [15:0] KBSR_ADDR   = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR   = 16'hFE02,
  parameter logic [15:0] DSR_ADDR    = 16'hFE04,
  parameter logic [15:0] DDR_ADDR    = 16'hFE06,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] MAR_OUT,
  input  logic [15:0] MDR_OUT,
  output logic [15:0] MIOMUX_OUT,
  output logic        R,
  output logic        ERR,
  output logic        MEM_EN,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_READY,
  input  logic        KB_VALID,
  input  logic [15:0] KB_DATA,
  output logic        KB_ACK,
  output logic        DISP_VALID,
  output logic [15:0] DISP_DATA,
  input  logic        DISP_READY,
  output logic        KB_INT,
  output logic [15:0] KBSR_OUT,
  output logic [15:0] DSR_OUT
);

  localparam int c_CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEV      = 2'd1,
    MEM_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_wr;
  logic                 r_kb_full;
  logic                 r_kb_ie;
  logic [15:0]          r_kbdr;
  logic                 r_disp_rdy;
  logic                 r_disp_ie;
  logic [15:0]          r_ddr;

  logic w_is_dev;
  logic w_kbdr_rd;

  assign w_is_dev  = (MAR_OUT == KBSR_ADDR) || (MAR_OUT == KBDR_ADDR) ||
                     (MAR_OUT == DSR_ADDR)  || (MAR_OUT == DDR_ADDR);
  assign w_kbdr_rd = (r_state == DEV) && !r_wr && (MEM_ADDR == KBDR_ADDR);

  assign KBSR_OUT  = {r_kb_full, r_kb_ie, 14'b0};
  assign DSR_OUT   = {r_disp_rdy, r_disp_ie, 14'b0};
  assign KB_INT    = r_kb_full & r_kb_ie;
  assign DISP_DATA = r_ddr;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      R          <= 1'b0;
      ERR        <= 1'b0;
      MEM_EN     <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      MIOMUX_OUT <= '0;
      KB_ACK     <= 1'b0;
      DISP_VALID <= 1'b0;
      r_kb_full  <= 1'b0;
      r_kb_ie    <= 1'b0;
      r_kbdr     <= '0;
      r_disp_rdy <= 1'b1;
      r_disp_ie  <= 1'b0;
      r_ddr      <= '0;
    end else begin
      R      <= 1'b0;
      ERR    <= 1'b0;
      MEM_EN <= 1'b0;
      KB_ACK <= 1'b0;

      // A KBDR read clearing the full flag beats a same-cycle keyboard offer.
      if (w_kbdr_rd) begin
        r_kb_full <= 1'b0;
      end else if (KB_VALID && !r_kb_full) begin
        r_kbdr    <= KB_DATA;
        r_kb_full <= 1'b1;
        KB_ACK    <= 1'b1;
      end

      if (DISP_VALID && DISP_READY) begin
        DISP_VALID <= 1'b0;
        r_disp_rdy <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (MIO_EN) begin
            MEM_ADDR  <= MAR_OUT;
            MEM_WDATA <= MDR_OUT;
            r_wr      <= R_W;
            r_cnt     <= '0;
            if (w_is_dev) begin
              r_state <= DEV;
            end else begin
              MEM_EN  <= 1'b1;
              MEM_WE  <= R_W;
              r_state <= MEM_WAIT;
            end
          end
        end

        DEV: begin
          R       <= 1'b1;
          r_state <= DONE;
          if (r_wr) begin
            case (MEM_ADDR)
              KBSR_ADDR: r_kb_ie   <= MEM_WDATA[14];
              DSR_ADDR:  r_disp_ie <= MEM_WDATA[14];
              DDR_ADDR: begin
                // A busy display silently drops the character.
                if (r_disp_rdy) begin
                  r_ddr      <= MEM_WDATA;
                  r_disp_rdy <= 1'b0;
                  DISP_VALID <= 1'b1;
                end
              end
              default: ;
            endcase
          end else begin
            case (MEM_ADDR)
              KBSR_ADDR: MIOMUX_OUT <= {r_kb_full, r_kb_ie, 14'b0};
              KBDR_ADDR: MIOMUX_OUT <= r_kbdr;
              DSR_ADDR:  MIOMUX_OUT <= {r_disp_rdy, r_disp_ie, 14'b0};
              default:   MIOMUX_OUT <= r_ddr;
            endcase
          end
        end

        MEM_WAIT: begin
          if (MEM_READY) begin
            if (!r_wr) MIOMUX_OUT <= MEM_RDATA;
            R       <= 1'b1;
            MEM_WE  <= 1'b0;
            r_state <= DONE;
          end else if (r_cnt == c_CNT_W'(MEM_TIMEOUT - 1)) begin
            MIOMUX_OUT <= '0;
            R          <= 1'b1;
            ERR        <= 1'b1;
            MEM_WE     <= 1'b0;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt + {{(c_CNT_W-1){1'b0}}, 1'b1};
          end
        end

        DONE: begin
          if (!MIO_EN) r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_mem_io_ctrl : directed self-checking bench for mem_io_ctrl.
//  Revision       : 1.0
// ============================================================================
module tb_mem_io_ctrl;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        MIO_EN, R_W;
  logic [15:0] MAR_OUT, MDR_OUT, MIOMUX_OUT;
  logic        R, ERR, MEM_EN, MEM_WE;
  logic [15:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic        MEM_READY;
  logic        KB_VALID;
  logic [15:0] KB_DATA;
  logic        KB_ACK, DISP_VALID;
  logic [15:0] DISP_DATA;
  logic        DISP_READY, KB_INT;
  logic [15:0] KBSR_OUT, DSR_OUT;

  int          n_total = 0;
  int          n_bad   = 0;

  int          mem_delay = -1;
  logic [15:0] mem_data  = '0;
  int          mem_en_cnt = 0;
  logic        mem_we_seen = 1'b0;
  logic [15:0] mem_addr_seen = '0;
  logic [15:0] mem_wd_seen = '0;

  mem_io_ctrl dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .MIO_EN     (MIO_EN),
    .R_W        (R_W),
    .MAR_OUT    (MAR_OUT),
    .MDR_OUT    (MDR_OUT),
    .MIOMUX_OUT (MIOMUX_OUT),
    .R          (R),
    .ERR        (ERR),
    .MEM_EN     (MEM_EN),
    .MEM_WE     (MEM_WE),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_WDATA  (MEM_WDATA),
    .MEM_RDATA  (MEM_RDATA),
    .MEM_READY  (MEM_READY),
    .KB_VALID   (KB_VALID),
    .KB_DATA    (KB_DATA),
    .KB_ACK     (KB_ACK),
    .DISP_VALID (DISP_VALID),
    .DISP_DATA  (DISP_DATA),
    .DISP_READY (DISP_READY),
    .KB_INT     (KB_INT),
    .KBSR_OUT   (KBSR_OUT),
    .DSR_OUT    (DSR_OUT)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // Latency counts edges from the one that samples MIO_EN through the one raising R.
  task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                           output logic [15:0] rd, output logic er, output int lat);
    MIO_EN  = 1'b1;
    R_W     = we;
    MAR_OUT = addr;
    MDR_OUT = wd;
    lat     = 0;
    do begin
      tick();
      lat++;
    end while (!R && lat < 40);
    chk("r_seen", {31'b0, R}, 32'd1);
    rd     = MIOMUX_OUT;
    er     = ERR;
    MIO_EN = 1'b0;
    R_W    = 1'b0;
  endtask

  // Memory responder: raises MEM_READY mem_delay cycles after the MEM_EN cycle.
  initial begin
    MEM_READY = 1'b0;
    MEM_RDATA = '0;
    forever begin
      @(posedge i_Clk);
      #2;
      if (MEM_EN) begin
        mem_en_cnt++;
        mem_we_seen   = MEM_WE;
        mem_addr_seen = MEM_ADDR;
        mem_wd_seen   = MEM_WDATA;
        if (mem_delay >= 0) begin
          repeat (mem_delay) begin
            @(posedge i_Clk);
            #2;
          end
          MEM_READY = 1'b1;
          MEM_RDATA = mem_data;
          @(posedge i_Clk);
          #2;
          MEM_READY = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;
    int          en0;
    int          rcnt;

    i_Rst = 1'b1; MIO_EN = 1'b0; R_W = 1'b0; MAR_OUT = '0; MDR_OUT = '0;
    KB_VALID = 1'b0; KB_DATA = '0; DISP_READY = 1'b0;
    repeat (3) tick();
    chk("rst_r",      {31'b0, R},          32'd0);
    chk("rst_err",    {31'b0, ERR},        32'd0);
    chk("rst_mem_en", {31'b0, MEM_EN},     32'd0);
    chk("rst_mux",    {16'b0, MIOMUX_OUT}, 32'h0000);
    chk("rst_kbsr",   {16'b0, KBSR_OUT},   32'h0000);
    chk("rst_dsr",    {16'b0, DSR_OUT},    32'h8000);
    chk("rst_dvalid", {31'b0, DISP_VALID}, 32'd0);
    i_Rst = 1'b0;

    // Memory read, ready 3 cycles after MEM_EN
    mem_delay = 3; mem_data = 16'h1234; en0 = mem_en_cnt;
    do_access(1'b0, 16'h3000, 16'h0000, rd, er, lat);
    chk("mrd_data", {16'b0, rd}, 32'h1234);
    chk("mrd_err",  {31'b0, er}, 32'd0);
    chk("mrd_lat",  lat,         32'd5);
    chk("mrd_en1",  mem_en_cnt - en0, 32'd1);
    tick();
    chk("mrd_rpulse", {31'b0, R}, 32'd0);

    // Memory write leaves MIOMUX_OUT untouched
    mem_delay = 1; en0 = mem_en_cnt;
    do_access(1'b1, 16'h4000, 16'hBEEF, rd, er, lat);
    chk("mwr_mux",  {16'b0, rd}, 32'h1234);
    chk("mwr_lat",  lat,         32'd3);
    chk("mwr_we",   {31'b0, mem_we_seen}, 32'd1);
    chk("mwr_addr", {16'b0, mem_addr_seen}, 32'h4000);
    chk("mwr_wd",   {16'b0, mem_wd_seen},   32'hBEEF);
    tick();

    // Timeout: R and ERR 16 cycles after MEM_EN
    mem_delay = -1;
    do_access(1'b0, 16'h3000, 16'h0000, rd, er, lat);
    chk("to_err", {31'b0, er}, 32'd1);
    chk("to_mux", {16'b0, rd}, 32'h0000);
    chk("to_lat", lat,         32'd17);
    tick();

    // Ready on the last allowed cycle is a success
    mem_delay = 15; mem_data = 16'h00C3;
    do_access(1'b0, 16'h3002, 16'h0000, rd, er, lat);
    chk("edge_err",  {31'b0, er}, 32'd0);
    chk("edge_data", {16'b0, rd}, 32'h00C3);
    chk("edge_lat",  lat,         32'd17);
    tick();

    // Keyboard
    KB_VALID = 1'b1; KB_DATA = 16'h0041;
    tick();
    chk("kb_ack", {31'b0, KB_ACK}, 32'd1);
    KB_VALID = 1'b0;
    tick();
    chk("kb_ack_pulse", {31'b0, KB_ACK}, 32'd0);
    do_access(1'b0, 16'hFE00, 16'h0000, rd, er, lat);
    chk("kbsr_full", {16'b0, rd}, 32'h8000);
    chk("dev_lat",   lat,         32'd2);
    tick();
    do_access(1'b0, 16'hFE02, 16'h0000, rd, er, lat);
    chk("kbdr_data", {16'b0, rd}, 32'h0041);
    tick();
    do_access(1'b0, 16'hFE00, 16'h0000, rd, er, lat);
    chk("kbsr_clr", {16'b0, rd}, 32'h0000);
    tick();

    // KBDR read in the same cycle as a new offer: old data, no load that cycle
    MIO_EN = 1'b1; R_W = 1'b0; MAR_OUT = 16'hFE02;
    tick();
    KB_VALID = 1'b1; KB_DATA = 16'h0066;
    tick();
    chk("race_r",    {31'b0, R},          32'd1);
    chk("race_old",  {16'b0, MIOMUX_OUT}, 32'h0041);
    chk("race_noack",{31'b0, KB_ACK},     32'd0);
    MIO_EN = 1'b0;
    tick();
    chk("race_ack_late", {31'b0, KB_ACK}, 32'd1);
    KB_VALID = 1'b0;
    tick();
    do_access(1'b0, 16'hFE02, 16'h0000, rd, er, lat);
    chk("race_new", {16'b0, rd}, 32'h0066);
    tick();

    // Display
    do_access(1'b1, 16'hFE06, 16'h0042, rd, er, lat);
    chk("disp_valid", {31'b0, DISP_VALID}, 32'd1);
    chk("disp_data",  {16'b0, DISP_DATA},  32'h0042);
    tick();
    do_access(1'b0, 16'hFE04, 16'h0000, rd, er, lat);
    chk("dsr_busy", {16'b0, rd}, 32'h0000);
    tick();
    do_access(1'b1, 16'hFE06, 16'h0099, rd, er, lat);
    chk("disp_drop_err",  {31'b0, er},        32'd0);
    chk("disp_drop_data", {16'b0, DISP_DATA}, 32'h0042);
    repeat (5) tick();
    chk("disp_hold", {31'b0, DISP_VALID}, 32'd1);
    DISP_READY = 1'b1;
    tick();
    DISP_READY = 1'b0;
    chk("disp_done", {31'b0, DISP_VALID}, 32'd0);
    do_access(1'b0, 16'hFE04, 16'h0000, rd, er, lat);
    chk("dsr_ready", {16'b0, rd}, 32'h8000);
    tick();
    do_access(1'b0, 16'hFE06, 16'h0000, rd, er, lat);
    chk("ddr_read", {16'b0, rd}, 32'h0042);
    tick();

    // Held request yields one access
    MIO_EN = 1'b1; R_W = 1'b0; MAR_OUT = 16'hFE04;
    rcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (R) rcnt++;
    end
    MIO_EN = 1'b0;
    tick();
    chk("held_one_r", rcnt, 32'd1);

    // Interrupt enable
    do_access(1'b1, 16'hFE00, 16'hFFFF, rd, er, lat);
    tick();
    do_access(1'b0, 16'hFE00, 16'h0000, rd, er, lat);
    chk("kbsr_ie", {16'b0, rd}, 32'h4000);
    chk("kbint_0", {31'b0, KB_INT}, 32'd0);
    KB_VALID = 1'b1; KB_DATA = 16'h0031;
    tick();
    KB_VALID = 1'b0;
    tick();
    chk("kbint_1", {31'b0, KB_INT}, 32'd1);

    // Reset during MEM_WAIT with a display character pending
    do_access(1'b1, 16'hFE06, 16'h0077, rd, er, lat);
    chk("pend_valid", {31'b0, DISP_VALID}, 32'd1);
    tick();
    mem_delay = -1;
    MIO_EN = 1'b1; R_W = 1'b0; MAR_OUT = 16'h3000;
    repeat (3) tick();
    #2;
    i_Rst = 1'b1;
    #1;
    chk("mrst_r",      {31'b0, R},          32'd0);
    chk("mrst_dvalid", {31'b0, DISP_VALID}, 32'd0);
    chk("mrst_dsr",    {16'b0, DSR_OUT},    32'h8000);
    chk("mrst_kbsr",   {16'b0, KBSR_OUT},   32'h0000);
    chk("mrst_mux",    {16'b0, MIOMUX_OUT}, 32'h0000);
    MIO_EN = 1'b0;
    repeat (2) tick();
    i_Rst = 1'b0;
    rcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (R) rcnt++;
    end
    chk("mrst_no_r", rcnt, 32'd0);
    mem_delay = 2; mem_data = 16'h5A5A;
    do_access(1'b0, 16'h3004, 16'h0000, rd, er, lat);
    chk("post_data", {16'b0, rd}, 32'h5A5A);
    chk("post_err",  {31'b0, er}, 32'd0);
    chk("post_lat",  lat,         32'd4);

    // First edge after reset release accepts a request
    tick();
    i_Rst = 1'b1;
    #2;
    i_Rst = 1'b0;
    do_access(1'b0, 16'hFE04, 16'h0000, rd, er, lat);
    chk("rel_lat", lat,         32'd2);
    chk("rel_dsr", {16'b0, rd}, 32'h8000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
